// File: rtl/mmio_pkg.sv
// Shared constants, RX state encoding and the address-decode helper for the MMIO port controller.
package mmio_pkg;

  localparam logic [15:0] MMIO_PORT_ADDR = 16'h0000;
  localparam int          WORD_W         = 16;

  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } rx_state_e;

  function automatic logic port_hit(input logic [15:0] addr);
    return (addr == MMIO_PORT_ADDR);
  endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Synchronous TX FIFO with power-of-two depth; the caller never pops when empty
// and only pushes when full if it pops in the same cycle.
module mmio_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/mmio_port_ctrl.sv
// MMIO port controller: address-0 stores feed a TX FIFO, loads consume a one-entry RX register.
// Optional sticky overflow flag on dropped stores when MMIO_OVERFLOW_EN is defined.
module mmio_port_ctrl
  import mmio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             cpu_we,
  input  logic             cpu_re,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
`ifdef MMIO_OVERFLOW_EN
  output logic             tx_full,
  output logic             ovf
`else
  output logic             tx_full
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            hit_s;
  logic            push_s;
  logic            pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [CW-1:0]   fifo_count_s;
  rx_state_e       rx_state_r;
  logic [WIDTH-1:0] rx_word_r;
  logic [WIDTH-1:0] cpu_rdata_s;

  assign hit_s  = port_hit(cpu_addr);
  assign pop_s  = !fifo_empty_s && tx_ready;
  // A store to a full FIFO still lands when the head leaves in the same cycle.
  assign push_s = cpu_we && hit_s && (!fifo_full_s || pop_s);

  mmio_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (cpu_wdata),
    .rdata (tx_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign tx_valid = !fifo_empty_s;
  assign tx_full  = (fifo_count_s == CW'(DEPTH));

  // RX holding register: capture when empty, release on a CPU load from the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_r <= RX_EMPTY;
      rx_word_r  <= {WIDTH{1'b0}};
    end else begin
      case (rx_state_r)
        RX_EMPTY: begin
          if (rx_valid) begin
            rx_state_r <= RX_FULL;
            rx_word_r  <= rx_data;
          end
        end
        RX_FULL: begin
          if (cpu_re && hit_s) rx_state_r <= RX_EMPTY;
        end
        default: rx_state_r <= RX_EMPTY;
      endcase
    end
  end

  assign rx_ready = (rx_state_r == RX_EMPTY);

  // Load data mux: only a hit on a full RX register returns data.
  always_comb begin
    cpu_rdata_s = {WIDTH{1'b0}};
    if (hit_s && (rx_state_r == RX_FULL)) begin
      cpu_rdata_s = rx_word_r;
    end else begin
      cpu_rdata_s = {WIDTH{1'b0}};
    end
  end

  assign cpu_rdata = cpu_rdata_s;

`ifdef MMIO_OVERFLOW_EN
  logic drop_s;
  logic ovf_r;

  assign drop_s = cpu_we && hit_s && fifo_full_s && !pop_s;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_r <= 1'b0;
    else     ovf_r <= ovf_r | drop_s;
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_mmio_port_ctrl.sv
// Self-checking bench for mmio_port_ctrl: directed steps then random traffic against a queue model.
module tb_mmio_port_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [15:0] cpu_wdata = 16'h0000;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [15:0] cpu_rdata;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = 16'h0000;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        tx_full;
`ifdef MMIO_OVERFLOW_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  mmio_port_ctrl #(.DEPTH(DEPTH), .WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
`ifdef MMIO_OVERFLOW_EN
    .tx_full   (tx_full),
    .ovf       (ovf)
`else
    .tx_full   (tx_full)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as a queue, RX as a flag plus word.
  logic [15:0] txq [$];
  bit          m_rx_full = 1'b0;
  logic [15:0] m_rx_word = 16'h0000;
  bit          m_ovf = 1'b0;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chkb("tx_valid", tx_valid, txq.size() != 0);
    chkb("tx_full", tx_full, txq.size() == DEPTH);
    chkb("rx_ready", rx_ready, !m_rx_full);
    if (txq.size() != 0) chk16("tx_data", tx_data, txq[0]);
`ifdef MMIO_OVERFLOW_EN
    chkb("ovf", ovf, m_ovf);
`endif
  endtask

  // One clock cycle: apply inputs, check the combinational load path, advance model and DUT.
  task automatic tick(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                      input logic re, input logic rv, input logic [15:0] rd, input logic tr);
    bit hit, pop, push, cap, con;
    logic [15:0] tmp;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_re = re;
    rx_valid = rv; rx_data = rd; tx_ready = tr;
    #1;
    hit = (addr == 16'h0000);
    chk16("cpu_rdata", cpu_rdata, (hit && m_rx_full) ? m_rx_word : 16'h0000);
    pop  = (txq.size() != 0) && tr;
    push = we && hit && ((txq.size() < DEPTH) || pop);
    if (we && hit && !push) m_ovf = 1'b1;
    cap = rv && !m_rx_full;
    con = re && hit && m_rx_full;
    if (pop) tmp = txq.pop_front();
    if (push) txq.push_back(wd);
    if (con) m_rx_full = 1'b0;
    if (cap) begin
      m_rx_full = 1'b1;
      m_rx_word = rd;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic idle(input logic tr);
    tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, tr);
  endtask

  task automatic store(input logic [15:0] addr, input logic [15:0] wd, input logic tr);
    tick(1'b1, addr, wd, 1'b0, 1'b0, 16'h0000, tr);
  endtask

  initial begin
    logic [15:0] exp_drain [4];
    exp_drain = '{16'h1002, 16'h1003, 16'h1004, 16'h00AA};

    // Async reset at power-up
    #1 rst = 1'b1;
    #2;
    chkb("reset_tx_valid", tx_valid, 1'b0);
    chkb("reset_tx_full", tx_full, 1'b0);
    chkb("reset_rx_ready", rx_ready, 1'b1);
`ifdef MMIO_OVERFLOW_EN
    chkb("reset_ovf", ovf, 1'b0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Two stores held back, then drained in order
    store(16'h0000, 16'h1234, 1'b0);
    chkb("store_latency", tx_valid, 1'b1);
    chk16("first_head", tx_data, 16'h1234);
    store(16'h0000, 16'hBEEF, 1'b0);
    chk16("head_held", tx_data, 16'h1234);
    idle(1'b1);
    chk16("second_head", tx_data, 16'hBEEF);
    idle(1'b1);
    chkb("drained_empty", tx_valid, 1'b0);

    // Fill to DEPTH, fifth store dropped
    for (int i = 1; i <= 5; i++) begin
      store(16'h0000, 16'h1000 + 16'(i), 1'b0);
      if (i == 4) chkb("full_after_4", tx_full, 1'b1);
    end
    chk16("head_after_drop", tx_data, 16'h1001);
`ifdef MMIO_OVERFLOW_EN
    chkb("ovf_set", ovf, 1'b1);
`endif

    // Store while full and popping: accepted, count stays at DEPTH
    store(16'h0000, 16'h00AA, 1'b1);
    chkb("full_push_pop", tx_full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk16("drain_order", tx_data, exp_drain[i]);
      idle(1'b1);
    end
    chkb("drain_done", tx_valid, 1'b0);

    // RX capture and consume
    tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h5A5A, 1'b0);
    chkb("rx_captured", rx_ready, 1'b0);
    cpu_addr = 16'h0000;
    #1;
    chk16("rx_visible", cpu_rdata, 16'h5A5A);
    tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    chkb("rx_released", rx_ready, 1'b1);

    // Load while empty and store to a non-port address
    tick(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk16("empty_load", cpu_rdata, 16'h0000);
    store(16'h0002, 16'h7777, 1'b0);
    chkb("miss_store", tx_valid, 1'b0);

    // Async reset with traffic in flight
    store(16'h0000, 16'h0101, 1'b0);
    store(16'h0000, 16'h0202, 1'b0);
    tick(1'b1, 16'h0000, 16'h0303, 1'b0, 1'b1, 16'hC3C3, 1'b0);
    #2 rst = 1'b1;
    #1;
    chkb("rst_mid_tx_valid", tx_valid, 1'b0);
    chkb("rst_mid_rx_ready", rx_ready, 1'b1);
`ifdef MMIO_OVERFLOW_EN
    chkb("rst_mid_ovf", ovf, 1'b0);
`endif
    txq.delete();
    m_rx_full = 1'b0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_regs();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      tick(1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_port_ctrl.md
# mmio_port_ctrl

Memory-mapped I/O port controller attached to the data-memory I/O window at address 0x0000. CPU stores to address 0 are buffered in a small TX FIFO and drained to an external consumer over a valid/ready handshake. Words arriving from an external producer are held in a one-entry RX register and returned to the CPU on loads from address 0. The block sits between the data-memory stage's I/O path and the board-level peripheral.

## Interface
Parameters:
- DEPTH, 4: TX FIFO entries; power of two, 2..16.
- WIDTH, 16: data word width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  16  data-memory address of the current access.
- cpu_wdata  in  WIDTH  store data.
- cpu_we  in  1  store strobe.
- cpu_re  in  1  load strobe; consumes RX word.
- cpu_rdata  out  WIDTH  load data for address 0.
- tx_data  out  WIDTH  FIFO head word.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts tx_data.
- rx_data  in  WIDTH  producer word.
- rx_valid  in  1  producer offers rx_data.
- rx_ready  out  1  RX register empty.
- tx_full  out  1  FIFO holds DEPTH entries.
- ovf  out  1  sticky TX overflow; present only with MMIO_OVERFLOW_EN.

## Operation
- Port hit: cpu_addr == 16'h0000. Accesses to any other address are ignored.
- Push: cpu_we && hit && (!tx_full || pop) writes cpu_wdata at the tail.
- Drop: cpu_we && hit && tx_full && !pop. The word is discarded and FIFO state is unchanged.
- Pop: tx_valid && tx_ready advances the head.
- Push and pop in the same cycle:
  - Count is unchanged.
  - When the FIFO is empty, the push still lands and tx_valid rises the next cycle; data never bypasses the FIFO.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Count is log2(DEPTH)+1 bits wide.
- tx_data is undefined while tx_valid = 0. Benches must not check it then.
- RX has two states, EMPTY and FULL:
  - EMPTY -> FULL on rx_valid && rx_ready; latches rx_data.
  - FULL -> EMPTY on cpu_re && hit.
  - rx_ready = (state == EMPTY).
- cpu_rdata (combinational):
  - RX word when hit && FULL.
  - 16'h0000 when hit && EMPTY.
  - 16'h0000 when not hit.
- A load while EMPTY returns 0 and changes no state.
- cpu_we and cpu_re high in the same cycle: both actions take effect independently.

## Timing
- Reset values, applied asynchronously:
  - FIFO pointers and count 0.
  - tx_valid 0, tx_full 0.
  - RX state EMPTY, so rx_ready 1.
  - ovf 0.
- Store-to-tx_valid latency is 1 cycle.
- tx_valid, tx_full and rx_ready are registered-state decodes; they are not combinational in the inputs.
- cpu_rdata is combinational in cpu_addr and RX state, valid in the same cycle as the load.
- Capture-to-readable latency: the word is visible on cpu_rdata 1 cycle after the rx handshake.
- After a CPU consume, rx_ready is 1 on the next cycle. The earliest new capture is one cycle after that.
- Asserting rst mid-transfer discards all FIFO and RX contents. No handshake completes in the reset cycle.

## Configuration
- MMIO_OVERFLOW_EN defined:
  - ovf is set on any drop and holds until rst.
  - ovf is a registered output.
- MMIO_OVERFLOW_EN undefined:
  - The ovf port and its flop are removed.
  - Drops are silent.

## Structure
- Package mmio_pkg holds:
  - MMIO_PORT_ADDR = 16'h0000.
  - WORD_W = 16.
  - The RX state enum (RX_EMPTY, RX_FULL).
- Sub-module mmio_tx_fifo: parameterized synchronous FIFO with push/pop/full/empty/count.
- The top level holds address decode, RX register/FSM and the ovf flag.

## Test plan
- Reset, then store 0x1234 and 0xBEEF to address 0 with tx_ready = 0 -> tx_valid = 1 after 1 cycle and tx_data = 0x1234. After raising tx_ready, 0x1234 then 0xBEEF pop on consecutive cycles, then tx_valid = 0.
- Store 5 words with DEPTH = 4 and tx_ready = 0 -> tx_full = 1 after the 4th store; the 5th is dropped; ovf = 1 with the macro defined. The drain yields exactly words 1–4.
- FIFO full, tx_ready = 1, store 0x00AA in the same cycle -> push accepted, count stays 4, 0x00AA emerges last.
- rx_valid with rx_data = 0x5A5A -> rx_ready = 0 next cycle. A load from address 0 returns 0x5A5A. The cycle after the consume, rx_ready = 1.
- Load from address 0 while EMPTY -> cpu_rdata = 0x0000, state unchanged. Store to address 0x0002 -> FIFO unchanged.
- Assert rst asynchronously with 3 words queued and RX FULL -> tx_valid = 0, rx_ready = 1, ovf = 0 immediately, before the next clock edge.
